// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the multicycle data memory.
//   F3_*          : RISC-V load/store funct3 encodings for access size/sign
//   dmem_state_t  : controller state, also exported on the debug port
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_mc_if.sv
// Request/response bus of the multicycle data memory.
//   req_valid/req_ready : request handshake
//   req_we, req_funct3, req_addr, req_wdata : request payload
//   rsp_valid, rsp_rdata, rsp_err : one-cycle response pulse
//   busy : a transaction is in flight
//
// Handshake: a request transfers on a rising clock edge where req_valid
// and req_ready are both 1; the payload must be stable while req_valid is 1
// and is ignored otherwise. There is no backpressure on the response:
// rsp_valid is high for exactly one cycle and rsp_rdata/rsp_err are only
// meaningful while it is high (they read 0 otherwise).
interface dmem_mc_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mem_subword_align.sv
// Combinational sub-word lane logic for byte/half/word accesses.
//   i_funct3  : access size/sign
//   i_lane    : byte address bits [1:0]
//   i_we      : 1 = store (unsigned sizes are illegal for stores)
//   i_rword   : raw memory word
//   i_wdata   : right-aligned store data
//   o_rdata   : sign/zero-extended load data
//   o_be      : byte enables for the store
//   o_wword   : store data replicated onto every lane; o_be picks the lane
//   o_misalign: halfword on odd address or word on non-zero lane
//   o_illegal : reserved funct3, or unsigned size used by a store
module mem_subword_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic        i_we,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic        o_misalign,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
  end

  always_comb begin
    o_rdata    = '0;
    o_be       = '0;
    o_wword    = '0;
    o_misalign = 1'b0;
    o_illegal  = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_rdata = {{24{w_byte[7]}}, w_byte};
        o_be    = 4'b0001 << i_lane;
        o_wword = {4{i_wdata[7:0]}};
      end
      F3_BU: begin
        o_rdata   = {24'd0, w_byte};
        o_illegal = i_we;
      end
      F3_H: begin
        o_rdata    = {{16{w_half[15]}}, w_half};
        o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wword    = {2{i_wdata[15:0]}};
        o_misalign = i_lane[0];
      end
      F3_HU: begin
        o_rdata    = {16'd0, w_half};
        o_misalign = i_lane[0];
        o_illegal  = i_we;
      end
      F3_W: begin
        o_rdata    = i_rword;
        o_be       = 4'b1111;
        o_wword    = i_wdata;
        o_misalign = |i_lane;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_mc.sv
// Multicycle data memory with byte/half/word loads and stores.
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset (memory contents kept)
//   bus         : request/response bus (slave side)
//   o_dbg_state : current controller state
// Parameters: DEPTH words (power of 2, 4..4096), LATENCY wait cycles
// (0..15), INIT_FILE image name.
module dmem_mc
  import riscv_mem_pkg::*;
#(
  parameter int    DEPTH     = 64,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  dmem_mc_if.slave    bus,
  output dmem_state_t o_dbg_state
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  dmem_state_t r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [31:0] r_mem [DEPTH];

  // With zero wait states the RESP entry edge is the accept edge itself, so
  // the access must use the live request rather than the latch.
  logic          w_sel_we;
  logic [2:0]    w_sel_f3;
  logic [31:0]   w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic [AW-1:0] w_idx;
  logic          w_range_err;
  logic [31:0]   w_rword;
  logic [31:0]   w_ldata;
  logic [3:0]    w_be;
  logic [31:0]   w_wword;
  logic          w_misalign;
  logic          w_illegal;
  logic          w_err;
  logic          w_enter_resp;

  assign w_sel_we    = (r_state == IDLE) ? bus.req_we     : r_we;
  assign w_sel_f3    = (r_state == IDLE) ? bus.req_funct3 : r_f3;
  assign w_sel_addr  = (r_state == IDLE) ? bus.req_addr   : r_addr;
  assign w_sel_wdata = (r_state == IDLE) ? bus.req_wdata  : r_wdata;

  assign w_idx       = w_sel_addr[AW+1:2];
  assign w_range_err = |w_sel_addr[31:AW+2];
  assign w_rword     = r_mem[w_idx];

  mem_subword_align u_align (
    .i_funct3   (w_sel_f3),
    .i_lane     (w_sel_addr[1:0]),
    .i_we       (w_sel_we),
    .i_rword    (w_rword),
    .i_wdata    (w_sel_wdata),
    .o_rdata    (w_ldata),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  assign w_err = w_range_err | w_misalign | w_illegal;

  // Gated by reset so a request presented while reset is held can never
  // write memory through the zero-wait-state path.
  assign w_enter_resp = reset &
    (((r_state == IDLE) & bus.req_valid & (LATENCY == 0)) |
     ((r_state == WAIT) & (r_cnt == 4'd0)));

  // Storage has no reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_sel_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_f3        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_f3    <= bus.req_funct3;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= LAT_M1;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || w_sel_we) ? 32'd0 : w_ldata;
      end
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dmem_mc.sv
// Bench for dmem_mc: three instances (LATENCY 2, 0, 3) checked every cycle
// against a byte-addressed behavioural model, plus literal expectations.
module tb_dmem_mc;
  import riscv_mem_pkg::*;

  localparam int DEPTH = 64;
  localparam int NB    = 4 * DEPTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [3];
  logic        d_valid [3];
  logic        d_we    [3];
  logic [2:0]  d_f3    [3];
  logic [31:0] d_addr  [3];
  logic [31:0] d_wdata [3];
  logic        m_ready [3];
  logic        m_valid [3];
  logic        m_err   [3];
  logic        m_busy  [3];
  logic [31:0] m_rdata [3];
  dmem_state_t m_state [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LG = (g == 0) ? 2 : (g == 1) ? 0 : 3;
    dmem_mc_if bus ();
    assign bus.req_valid  = d_valid[g];
    assign bus.req_we     = d_we[g];
    assign bus.req_funct3 = d_f3[g];
    assign bus.req_addr   = d_addr[g];
    assign bus.req_wdata  = d_wdata[g];
    assign m_ready[g]     = bus.req_ready;
    assign m_valid[g]     = bus.rsp_valid;
    assign m_rdata[g]     = bus.rsp_rdata;
    assign m_err[g]       = bus.rsp_err;
    assign m_busy[g]      = bus.busy;
    dmem_mc #(.DEPTH(DEPTH), .LATENCY(LG), .INIT_FILE("")) u_dut (
      .clk         (clk),
      .reset       (rst_n[g]),
      .bus         (bus.slave),
      .o_dbg_state (m_state[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 0 : 3;
  endfunction

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // ---------------- behavioural model ----------------
  logic [7:0]  mmem   [3][NB];
  bit          pend   [3];
  bit          p_we   [3];
  logic [2:0]  p_f3   [3];
  logic [31:0] p_addr [3];
  logic [31:0] p_wd   [3];
  int          resp_at[3];
  int          free_at[3];
  logic [31:0] e_rdata[3];
  bit          e_err  [3];

  // Apply one access to the byte-addressed model memory.
  function automatic void model_eval(input int i);
    int sz;
    bit err;
    int a;
    logic [31:0] v;
    err = 0;
    sz  = 4;
    case (p_f3[i])
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    err = 1;
    endcase
    if (p_addr[i] >= NB) err = 1;
    if ((int'(p_addr[i][1:0]) % sz) != 0) err = 1;
    if (p_we[i] && p_f3[i][2]) err = 1;
    e_err[i]   = err;
    e_rdata[i] = 32'd0;
    if (!err) begin
      a = int'(p_addr[i][7:0]);
      if (p_we[i]) begin
        for (int b = 0; b < sz; b++) mmem[i][a+b] = p_wd[i][8*b +: 8];
      end else begin
        v = 32'd0;
        for (int b = 0; b < sz; b++) v[8*b +: 8] = mmem[i][a+b];
        if (!p_f3[i][2]) begin
          if (sz == 1 && v[7])  v[31:8]  = '1;
          if (sz == 2 && v[15]) v[31:16] = '1;
        end
        e_rdata[i] = v;
      end
    end
  endfunction

  // Accept when idle; result becomes visible L edges after the accept edge
  // and the block is ready again one edge later.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst_n[i]) begin
        if (d_valid[i] && cyc > free_at[i]) begin
          pend[i]    = 1;
          p_we[i]    = d_we[i];
          p_f3[i]    = d_f3[i];
          p_addr[i]  = d_addr[i];
          p_wd[i]    = d_wdata[i];
          resp_at[i] = cyc + lat_of(i);
          free_at[i] = cyc + lat_of(i) + 1;
        end
        if (pend[i] && cyc == resp_at[i]) begin
          model_eval(i);
          pend[i] = 0;
        end
      end
    end
  end

  // ---------------- compare + monitor ----------------
  int          rsp_cnt   [3];
  int          last_cyc  [3];
  logic [31:0] last_rdata[3];
  bit          last_err  [3];
  logic [31:0] obs_q[$];
  int          obs_cyc[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit          xv, xr, xe;
      logic [31:0] xd;
      xv = (cyc == resp_at[i]) && !pend[i];
      xr = (cyc >= free_at[i]);
      xd = xv ? e_rdata[i] : 32'd0;
      xe = xv ? e_err[i] : 1'b0;
      n_checks++;
      if (m_valid[i] !== xv || m_ready[i] !== xr || m_busy[i] !== !xr ||
          m_rdata[i] !== xd || m_err[i] !== xe) begin
        n_errs++;
        $display("FAIL cycle_cmp[%0d] cyc=%0d: got v=%0b r=%0b b=%0b d=%h e=%0b, expected v=%0b r=%0b b=%0b d=%h e=%0b",
                 i, cyc, m_valid[i], m_ready[i], m_busy[i], m_rdata[i], m_err[i],
                 xv, xr, !xr, xd, xe);
      end
      if (m_valid[i]) begin
        rsp_cnt[i]++;
        last_cyc[i]   = cyc;
        last_rdata[i] = m_rdata[i];
        last_err[i]   = m_err[i];
        if (i == 1) begin
          obs_q.push_back(m_rdata[i]);
          obs_cyc.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_req(input int i, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int acc, output bit ok);
    @(negedge clk);
    d_we[i] = we; d_f3[i] = f3; d_addr[i] = addr; d_wdata[i] = wd;
    d_valid[i] = 1'b1;
    ok  = 0;
    acc = 0;
    for (int n = 0; n < 40; n++) begin
      if (m_ready[i]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++; n_errs++;
      $display("FAIL accept_timeout[%0d]: got no req_ready, expected ready within 40 cycles", i);
      d_valid[i] = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(negedge clk);
    d_valid[i] = 1'b0;
  endtask

  task automatic do_req(input int i, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output bit got);
    int acc;
    int cnt0;
    bit ok;
    cnt0 = rsp_cnt[i];
    got  = 0;
    lat  = -1;
    start_req(i, we, f3, addr, wd, acc, ok);
    if (!ok) return;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (rsp_cnt[i] != cnt0) begin
        got = 1;
        lat = last_cyc[i] + 1 - acc;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++; n_errs++;
      $display("FAIL rsp_timeout[%0d]: got no rsp_valid, expected a response", i);
    end
  endtask

  task automatic xact(input int i, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e, input string name);
    int lat;
    bit got;
    do_req(i, we, f3, addr, wd, lat, got);
    if (got) begin
      chk({name, "_rdata"}, last_rdata[i], exp_d);
      chk({name, "_err"}, 32'(last_err[i]), 32'(exp_e));
      chk({name, "_lat"}, 32'(lat), 32'(lat_of(i) + 1));
    end
  endtask

  // Caller sits on a negedge; reset is asserted mid-cycle.
  task automatic pulse_reset(input int i, input string name);
    #2;
    rst_n[i]   = 1'b0;
    pend[i]    = 0;
    resp_at[i] = -10;
    free_at[i] = 0;
    #1;
    chk({name, "_valid"}, 32'(m_valid[i]), 32'd0);
    chk({name, "_rdata"}, m_rdata[i], 32'd0);
    chk({name, "_err"},   32'(m_err[i]), 32'd0);
    chk({name, "_ready"}, 32'(m_ready[i]), 32'd1);
    chk({name, "_busy"},  32'(m_busy[i]), 32'd0);
    chk({name, "_state"}, 32'(m_state[i]), 32'(IDLE));
    @(negedge clk);
    #2;
    rst_n[i] = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] burst_vals [4];

  initial begin
    int lat, acc;
    bit got, ok;
    logic [31:0] addr;
    int r;

    burst_vals = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_8000, 32'h0000_7FFF};
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b1; d_valid[i] = 1'b0; d_we[i] = 1'b0; d_f3[i] = '0;
      d_addr[i] = '0; d_wdata[i] = '0;
      pend[i] = 0; resp_at[i] = -10; free_at[i] = 0; rsp_cnt[i] = 0;
    end
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_state", 32'(m_state[i]), 32'(IDLE));
      chk("reset_ready", 32'(m_ready[i]), 32'd1);
    end
    #2;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Known contents everywhere so the model can predict every load.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < DEPTH; w++)
        do_req(i, 1'b1, F3_W, 32'(w * 4), $urandom, lat, got);

    // Directed, LATENCY=2.
    xact(0, 1, F3_W,  32'h10, 32'hDEAD_BEEF, 32'h0,         0, "sw_10");
    xact(0, 0, F3_W,  32'h10, 32'h0,         32'hDEAD_BEEF, 0, "lw_10");
    xact(0, 1, F3_W,  32'h20, 32'h0,         32'h0,         0, "sw_20");
    xact(0, 1, F3_B,  32'h21, 32'h0000_00A5, 32'h0,         0, "sb_21");
    xact(0, 0, F3_W,  32'h20, 32'h0,         32'h0000_A500, 0, "lw_20");
    xact(0, 0, F3_B,  32'h21, 32'h0,         32'hFFFF_FFA5, 0, "lb_21");
    xact(0, 0, F3_BU, 32'h21, 32'h0,         32'h0000_00A5, 0, "lbu_21");
    xact(0, 1, F3_W,  32'h30, 32'h1122_3344, 32'h0,         0, "sw_30");
    xact(0, 1, F3_H,  32'h32, 32'h0000_F00D, 32'h0,         0, "sh_32");
    xact(0, 0, F3_W,  32'h30, 32'h0,         32'hF00D_3344, 0, "lw_30");
    xact(0, 0, F3_H,  32'h32, 32'h0,         32'hFFFF_F00D, 0, "lh_32");
    xact(0, 0, F3_HU, 32'h32, 32'h0,         32'h0000_F00D, 0, "lhu_32");
    xact(0, 1, F3_W,  32'h12, 32'h5555_5555, 32'h0,         1, "sw_12_misalign");
    xact(0, 0, F3_W,  32'h10, 32'h0,         32'hDEAD_BEEF, 0, "lw_10_unchanged");
    xact(0, 0, F3_H,  32'h31, 32'h0,         32'h0,         1, "lh_31_misalign");
    xact(0, 0, F3_W,  32'h100, 32'h0,        32'h0,         1, "lw_100_range");
    xact(0, 0, 3'b011, 32'h10, 32'h0,        32'h0,         1, "f3_011");
    xact(0, 1, F3_HU, 32'h30, 32'hFFFF_FFFF, 32'h0,         1, "store_f3_101");
    xact(0, 0, F3_W,  32'h30, 32'h0,         32'hF00D_3344, 0, "lw_30_unchanged");

    // Reset during RESP: the store has already committed.
    xact(0, 1, F3_W, 32'h44, 32'h0BAD_CAFE, 32'h0, 0, "sw_44");
    start_req(0, 1, F3_W, 32'h44, 32'hA5A5_A5A5, acc, ok);
    if (ok) begin
      while (cyc < acc + lat_of(0)) @(negedge clk);
      #1;
      chk("resp_before_reset", 32'(m_valid[0]), 32'd1);
      pulse_reset(0, "rst_in_resp");
      xact(0, 0, F3_W, 32'h44, 32'h0, 32'hA5A5_A5A5, 0, "lw_44_committed");
    end

    // Reset during WAIT (LATENCY=3): the pending store is dropped.
    xact(2, 1, F3_W, 32'h40, 32'hCAFE_F00D, 32'h0, 0, "sw_40");
    start_req(2, 1, F3_W, 32'h40, 32'h1234_5678, acc, ok);
    if (ok) begin
      chk("wait_before_reset", 32'(m_busy[2]), 32'd1);
      pulse_reset(2, "rst_in_wait");
      xact(2, 0, F3_W, 32'h40, 32'h0, 32'hCAFE_F00D, 0, "lw_40_aborted");
    end

    // LATENCY=0: req_valid held high over four loads.
    for (int k = 0; k < 4; k++)
      xact(1, 1, F3_W, 32'(k * 4), burst_vals[k], 32'h0, 0, "burst_fill");
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(burst_vals[k]);
    @(negedge clk);
    d_we[1] = 1'b0; d_f3[1] = F3_W; d_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_addr[1] = 32'(k * 4);
      ok = 0;
      for (int n = 0; n < 10; n++) begin
        if (m_ready[1]) begin ok = 1; break; end
        @(negedge clk);
      end
      if (!ok) begin
        n_checks++; n_errs++;
        $display("FAIL burst_accept: got no req_ready, expected ready every 2nd cycle");
      end
      @(negedge clk);
    end
    d_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("burst_count", 32'(obs_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (obs_q.size() > 0) chk("burst_rdata", obs_q.pop_front(), exp_q.pop_front());
    end
    for (int k = 1; k < obs_cyc.size(); k++)
      chk("burst_gap", 32'(obs_cyc[k] - obs_cyc[k-1]), 32'd2);

    // Randomized traffic on all three instances.
    for (int i = 0; i < 3; i++) begin
      for (int t = 0; t < 60; t++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      addr = $urandom;
        else if (r == 1) addr = 32'(NB + $urandom_range(0, 15));
        else begin
          addr = 32'($urandom_range(0, NB - 1));
          if (r >= 6) addr[1:0] = 2'b00;
        end
        do_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, lat, got);
      end
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
